step_gen: RTL
=============

STEP_GEN -- requirements
Module: step_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the period, step-limit and step-count fields.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-004 SHALL have port run_i, input, 1 bit: level request to issue integration steps.
REQ-005 SHALL have port period_i, input, CNT_W bits: clock cycles from one step's acceptance to the next start_o.
REQ-006 SHALL have port n_steps_i, input, CNT_W bits: number of steps per run; 0 means free-running.
REQ-007 SHALL have port en_i, input, 1 bit: enable returned by the control unit.
REQ-008 SHALL have port sel_i, input, 1 bit: select returned by the control unit (0 on first step, 1 afterwards).
REQ-009 SHALL have port start_o, output, 1 bit: single-cycle start pulse to the control unit.
REQ-010 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port done_o, output, 1 bit: single-cycle pulse when n_steps_i steps have completed.
REQ-012 SHALL have port step_cnt_o, output, CNT_W bits: steps accepted since the last run start.
REQ-013 SHALL have port err_o, output, 1 bit: sticky handshake-error flag.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT, FIRE, ACK and DONE; all outputs SHALL be registered.
REQ-015 IDLE with run_i=1 SHALL latch period_i and n_steps_i, clear step_cnt_o and err_o, load the timer with max(period_i,1)-1, and enter WAIT.
REQ-016 WAIT SHALL decrement the timer each cycle and enter FIRE in the cycle after the timer reads 0; if run_i=0, WAIT SHALL return to IDLE.
REQ-017 FIRE SHALL assert start_o for exactly one cycle and enter ACK.
REQ-018 ACK SHALL sample en_i in the cycle following FIRE, because the control unit enables one cycle after sampling start.
REQ-019 In ACK with en_i=1 and the correct sel_i, step_cnt_o SHALL increment, wrapping at 2^CNT_W.
REQ-020 After a correct ACK: if latched n_steps is nonzero and step_cnt_o+1 equals it, the FSM SHALL enter DONE; else, if run_i=1, it SHALL reload the timer and enter WAIT; else it SHALL enter IDLE.
REQ-021 The correct sel_i SHALL be 0 when step_cnt_o is 0 and 1 otherwise.
REQ-022 In ACK with en_i=0 or a wrong sel_i, err_o SHALL set, step_cnt_o SHALL hold, and the FSM SHALL enter IDLE.
REQ-023 DONE SHALL pulse done_o for one cycle and then enter IDLE; a new run SHALL require run_i=1 while in IDLE.
REQ-024 Changes to period_i or n_steps_i outside IDLE SHALL have no effect until the next run.
REQ-025 Deasserting run_i during FIRE or ACK SHALL let the current step complete before the FSM returns to IDLE.

Reset
REQ-026 With rst_ni=0 the FSM SHALL go to IDLE, the timer SHALL clear, and start_o, busy_o, done_o, err_o and step_cnt_o SHALL be 0; operation SHALL resume on the first clock edge after deassertion.
REQ-027 Reset asserted mid-step SHALL abort the step without emitting done_o.

Configuration
REQ-028 With macro STEP_GEN_ERRCHK_EN defined, the checks in REQ-021 and REQ-022 SHALL be active.
REQ-029 Without STEP_GEN_ERRCHK_EN, err_o SHALL be tied to 0, and ACK SHALL treat every cycle as a correct acceptance regardless of en_i and sel_i.

Structure
REQ-030 Package step_gen_pkg SHALL hold the FSM state enumeration and the default CNT_W constant.
REQ-031 The period down-counter SHALL be a sub-module step_timer (load, decrement, zero flag).

Verification
REQ-032 period=4, n_steps=3, cu model responding: start_o pulses spaced 6 cycles apart (timer plus FIRE/ACK), then done_o once, step_cnt_o=3, and busy_o falls.
REQ-033 period=0: behaves as period=1, giving a start_o pulse every 3 cycles.
REQ-034 With ERRCHK on, en_i held 0 in ACK: err_o=1, FSM in IDLE, step_cnt_o=0; err_o clears on the next run.
REQ-035 With ERRCHK on, sel_i=1 on the first step: err_o=1; without the macro: step accepted and err_o=0.
REQ-036 n_steps=0, run_i dropped after 5 steps: no done_o, step_cnt_o=5, and IDLE is reached after the in-flight step.
REQ-037 rst_ni pulsed low during WAIT: all outputs 0 immediately, and no start_o until run_i is reapplied.

Source files
------------

// File: rtl/step_gen_pkg.sv
// Shared definitions for the step generator: FSM state encoding and default field width.
package step_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FIRE,
    ST_ACK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/step_gen_timer.sv
// Period down-counter for step_gen: loadable, decrements toward zero and holds there.
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/step_gen.sv
// Integration step generator: periodic start pulses with en/sel acceptance handshake.
// Optional handshake checking is enabled by defining STEP_GEN_ERRCHK_EN.
module step_gen
  import step_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] n_steps_i,
  input  logic             en_i,
  input  logic             sel_i,
  output logic             start_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] step_cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] ONE = 1;

  // Timer reload: a period of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] reload_val(input logic [CNT_W-1:0] p);
    return (p == '0) ? '0 : p - ONE;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, nsteps_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             start_q, busy_q, done_q;
  logic             latch, tmr_load, tmr_dec, tmr_zero, ack_ok;
  logic [CNT_W-1:0] tmr_val;

`ifdef STEP_GEN_ERRCHK_EN
  assign ack_ok = en_i && (sel_i == (cnt_q != '0));
  assign err_o  = err_q;
`else
  logic unused_hs;
  assign unused_hs = ^{en_i, sel_i, err_q};
  assign ack_ok    = 1'b1;
  assign err_o     = 1'b0;
`endif

  assign tmr_val = (state_q == ST_IDLE) ? reload_val(period_i) : reload_val(period_q);

  step_timer #(.W(CNT_W)) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    latch    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) begin
          latch    = 1'b1;
          cnt_d    = '0;
          err_d    = 1'b0;
          tmr_load = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!run_i) begin
          state_d = ST_IDLE;
        end else if (tmr_zero) begin
          state_d = ST_FIRE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_FIRE: state_d = ST_ACK;
      // en_i/sel_i arrive one cycle after the control unit sees start_o.
      ST_ACK: begin
        if (ack_ok) begin
          cnt_d = cnt_q + ONE;
          if ((nsteps_q != '0) && (cnt_d == nsteps_q)) begin
            state_d = ST_DONE;
          end else if (run_i) begin
            tmr_load = 1'b1;
            state_d  = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      start_q <= (state_d == ST_FIRE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  // Run parameters are captured once per run and ignored afterwards.
  always_ff @(posedge clk_i) begin
    if (latch) begin
      period_q <= period_i;
      nsteps_q <= n_steps_i;
    end
  end

  assign start_o    = start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign step_cnt_o = cnt_q;

endmodule
